// File: rtl/flags_collector.sv
// flags_collector: gathers per-element overflow flags from the PE array over a
// matmul operation into a sticky vector, then issues one write of that vector
// to the flags register and pulses done to the controller.
//
// Optional feature macro: FLAGS_IRQ_EN
//   defined   -> irq_o / irq_clr_i ports and a sticky level interrupt exist
//   undefined -> no interrupt ports or logic
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i
// COLLECT | OR-ing pe_flags_i into the sticky vector until TGT beats seen
// COMMIT  | write_enable_o high for one cycle, data_o holds the final vector
// DONE    | done_o high for one cycle, then back to IDLE
module flags_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int F         = MAX_DIM * MAX_DIM
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [15:0]          beats_i,
    input  logic                 accum_i,
    input  logic [F-1:0]         flags_prev_i,
    input  logic                 pe_valid_i,
    input  logic [F-1:0]         pe_flags_i,
`ifdef FLAGS_IRQ_EN
    input  logic                 irq_clr_i,
    output logic                 irq_o,
`endif
    output logic                 write_enable_o,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [F-1:0] sticky_q, sticky_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  tgt_q, tgt_d;
    logic         start_acc;

    // Next-state and datapath update; a start in IDLE or COLLECT (re)seeds the
    // operation and any beat presented in the same cycle is dropped.
    always_comb begin
        state_d   = state_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        start_acc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (start_i) begin
                    start_acc = 1'b1;
                end else if (pe_valid_i) begin
                    sticky_d = sticky_q | pe_flags_i;
                    cnt_d    = cnt_q + 16'd1;
                    if ((cnt_q + 16'd1) == tgt_q) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_acc) begin
            sticky_d = accum_i ? flags_prev_i : '0;
            cnt_d    = 16'd0;
            tgt_d    = beats_i;
            state_d  = (beats_i == 16'd0) ? ST_COMMIT : ST_COLLECT;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            sticky_q <= '0;
            cnt_q    <= 16'd0;
            tgt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
        end
    end

    // Outputs come straight from flops so no input reaches an output combinationally.
    always_comb begin
        write_enable_o = (state_q == ST_COMMIT);
        done_o         = (state_q == ST_DONE);
        busy_o         = (state_q != ST_IDLE);
        data_o         = BUS_WIDTH'(sticky_q);
    end

`ifdef FLAGS_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt sets after a commit of a non-zero vector; a set outranks a
    // same-cycle clear so an overflow event is never lost.
    always_comb begin
        irq_d = irq_q;
        if ((state_q == ST_COMMIT) && (|sticky_q)) begin
            irq_d = 1'b1;
        end else if (irq_clr_i || start_acc) begin
            irq_d = 1'b0;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_flags_collector.sv
// Scoreboard bench for flags_collector: the driver issues randomized operations
// and pushes the expected committed vector with its expected write cycle; a
// monitor pops and compares on every write_enable_o.
module tb_flags_collector;

    localparam int DW = 32;
    localparam int BW = 64;
    localparam int F  = (BW / DW) * (BW / DW);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [15:0]   beats_i;
    logic          accum_i;
    logic [F-1:0]  flags_prev_i;
    logic          pe_valid_i;
    logic [F-1:0]  pe_flags_i;
    logic          write_enable_o;
    logic [BW-1:0] data_o;
    logic          busy_o;
    logic          done_o;
`ifdef FLAGS_IRQ_EN
    logic          irq_clr_i;
    logic          irq_o;
`endif

    flags_collector #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .beats_i        (beats_i),
        .accum_i        (accum_i),
        .flags_prev_i   (flags_prev_i),
        .pe_valid_i     (pe_valid_i),
        .pe_flags_i     (pe_flags_i),
`ifdef FLAGS_IRQ_EN
        .irq_clr_i      (irq_clr_i),
        .irq_o          (irq_o),
`endif
        .write_enable_o (write_enable_o),
        .data_o         (data_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [BW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [F-1:0] rf();
        return F'($urandom_range(0, (1 << F) - 1));
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Random filler for cycles where the DUT should ignore start/beats.
    task automatic junk(input bit st);
        start_i      = st;
        accum_i      = 1'($urandom_range(0, 1));
        flags_prev_i = rf();
        beats_i      = 16'($urandom_range(0, 7));
        pe_valid_i   = 1'($urandom_range(0, 1));
        pe_flags_i   = rf();
`ifdef FLAGS_IRQ_EN
        irq_clr_i    = ($urandom_range(0, 9) == 0);
`endif
    endtask

    task automatic push(input logic [F-1:0] v, input int at);
        exp_t e;
        e.data = BW'(v);
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // One complete operation (optionally aborted and restarted once), followed
    // by two cycles of stray start requests landing in COMMIT and DONE.
    task automatic run_op(input bit acc, input logic [F-1:0] prev, input int beats,
                          input int gap_pct, input int abort_at,
                          input bit acc2, input logic [F-1:0] prev2, input int beats2,
                          input bit use_fixed, input logic [8*F-1:0] fixed);
        logic [F-1:0] expv;
        logic [F-1:0] f;
        int b, sent, ab, fidx;
        step();
        junk(1'b0);
        start_i      = 1'b1;
        accum_i      = acc;
        flags_prev_i = prev;
        beats_i      = 16'(beats);
        expv = acc ? prev : '0;
        b = beats; sent = 0; ab = abort_at; fidx = 0;
        if (b == 0) push(expv, cyc + 1);
        while (sent < b) begin
            step();
            junk(1'b0);
            if (ab >= 0 && sent == ab) begin
                start_i      = 1'b1;
                accum_i      = acc2;
                flags_prev_i = prev2;
                beats_i      = 16'(beats2);
                pe_valid_i   = 1'b1;
                expv = acc2 ? prev2 : '0;
                b = beats2; sent = 0; ab = -1;
                if (b == 0) push(expv, cyc + 1);
            end else if (int'($urandom_range(0, 99)) < gap_pct) begin
                pe_valid_i = 1'b0;
            end else begin
                f = use_fixed ? fixed[fidx*F +: F] : rf();
                fidx++;
                pe_valid_i = 1'b1;
                pe_flags_i = f;
                expv = expv | f;
                sent++;
                if (sent == b) push(expv, cyc + 1);
            end
        end
        step();
        junk(1'b1);
        step();
        junk(1'($urandom_range(0, 1)));
    endtask

    // Monitor: compares every write against the scoreboard and checks the
    // done pulse and return to idle that follow it.
    int done_due = -10;
`ifdef FLAGS_IRQ_EN
    logic irq_exp = 1'b0;
`endif
    always @(negedge clk_i) begin
        exp_t e;
        if (write_enable_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("write_data", data_o, e.data);
                chk("write_cycle", BW'(cyc), BW'(e.cyc));
                chk("busy_at_write", BW'(busy_o), BW'(1));
            end
            done_due = cyc + 1;
        end
        if (done_o === 1'b1 || cyc == done_due)
            chk("done_pulse", BW'(done_o), BW'(cyc == done_due));
        if (cyc == done_due + 1)
            chk("busy_after_done", BW'(busy_o), BW'(0));
`ifdef FLAGS_IRQ_EN
        chk("irq", BW'(irq_o), BW'(irq_exp));
        if (!rst_ni)
            irq_exp = 1'b0;
        else if (write_enable_o && (data_o != '0))
            irq_exp = 1'b1;
        else if (irq_clr_i || (start_i && !write_enable_o && !done_o))
            irq_exp = 1'b0;
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, ab, b2;
        rst_ni = 1'b0;
        junk(1'b0);
        start_i = 1'b0;
`ifdef FLAGS_IRQ_EN
        irq_clr_i = 1'b0;
`endif
        step();
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("reset_we", BW'(write_enable_o), BW'(0));
        chk("reset_data", data_o, BW'(0));
        chk("reset_busy", BW'(busy_o), BW'(0));
        chk("reset_done", BW'(done_o), BW'(0));

        // Directed operations from the test plan.
        run_op(1'b0, 4'h0, 3, 0, -1, 1'b0, 4'h0, 0, 1'b1, 32'h0000_0401);
        run_op(1'b1, 4'h8, 2, 40, -1, 1'b0, 4'h0, 0, 1'b1, 32'h0000_0011);
        run_op(1'b1, 4'h6, 0, 0, -1, 1'b0, 4'h0, 0, 1'b0, 32'h0);
        run_op(1'b0, 4'h0, 4, 0, 2, 1'b0, 4'h0, 1, 1'b1, 32'h0000_02FF);

        // Reset in the middle of COLLECT: nothing gets written.
        step();
        junk(1'b0);
        start_i = 1'b1;
        accum_i = 1'b1;
        beats_i = 16'd5;
        step();
        junk(1'b0);
        pe_valid_i = 1'b1;
        step();
        junk(1'b0);
        rst_ni = 1'b0;
        step();
        junk(1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_we", BW'(write_enable_o), BW'(0));
        chk("midrst_data", data_o, BW'(0));
        chk("midrst_busy", BW'(busy_o), BW'(0));
        chk("midrst_done", BW'(done_o), BW'(0));

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            beats = $urandom_range(0, 6);
            ab = (beats > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, beats - 1)) : -1;
            b2 = $urandom_range(0, 4);
            run_op(1'($urandom_range(0, 1)), rf(), beats, 30, ab,
                   1'($urandom_range(0, 1)), rf(), b2, 1'b0, 32'h0);
        end

        step();
        junk(1'b0);
        start_i = 1'b0;
        repeat (4) step();
        chk("pending_writes", BW'(exp_q.size()), BW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/flags_collector.md
# flags_collector

Upstream feeder for the matmul overflow-flags register. During a matmul operation it samples the per-element overflow/underflow flags produced by the PE array beat by beat and ORs them into a sticky MAX_DIM×MAX_DIM vector. At end of operation it issues a single-cycle write into the flags register, then signals completion to the controller. Optionally it raises a level interrupt when any element overflowed.

## Interface
- DATA_WIDTH, 32, operand/element width
- BUS_WIDTH, 64, bus width; also width of the write data to the flags register
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, matrix dimension; flag vector is MAX_DIM*MAX_DIM bits (F)

- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- start_i  in  1  start pulse for a new operation
- beats_i  in  16  number of valid PE beats in the operation, sampled on accepted start
- accum_i  in  1  1: seed sticky vector from flags_prev_i; 0: seed with zero; sampled on accepted start
- flags_prev_i  in  F  current flags-register contents
- pe_valid_i  in  1  PE array presents a flag beat this cycle
- pe_flags_i  in  F  per-element flags for this beat, bit r*MAX_DIM+c = element (r,c)
- write_enable_o  out  1  one-cycle write strobe to the flags register
- data_o  out  BUS_WIDTH  {zeros, sticky[F-1:0]}, registered
- busy_o  out  1  high in COLLECT, COMMIT and DONE
- done_o  out  1  one-cycle completion pulse
- irq_o, irq_clr_i  out/in  1  present only with FLAGS_IRQ_EN

## Operation
- Sticky register S[F-1:0], beat counter CNT[15:0], target TGT[15:0].
- States: IDLE, COLLECT, COMMIT, DONE.
- IDLE: start_i=1 → S = accum_i ? flags_prev_i : 0, CNT=0, TGT=beats_i; next state COLLECT, or COMMIT if beats_i==0.
- COLLECT: pe_valid_i=1 → S |= pe_flags_i, CNT+=1; if CNT+1==TGT → COMMIT. pe_valid_i=0 → hold.
- COLLECT + start_i=1: abort-and-restart. Reinitialise S/CNT/TGT from current inputs exactly as in IDLE; the concurrent pe_valid_i beat is discarded; no write issued for the aborted operation.
- COMMIT: write_enable_o=1 for exactly this cycle; data_o = {(BUS_WIDTH-F) zeros, S}. Next state DONE.
- DONE: done_o=1 for this cycle; next state IDLE.
- start_i in COMMIT or DONE is ignored (not queued).
- pe_valid_i outside COLLECT is ignored.
- data_o tracks S at all times; consumers qualify with write_enable_o.
- OR accumulation only; no arithmetic, no wrap: CNT never exceeds TGT.

## Timing
- Reset (rst_ni=0 at clock edge): state IDLE, S=0, CNT=0, TGT=0, write_enable_o=0, data_o=0, busy_o=0, done_o=0, irq_o=0. Reset mid-operation aborts with no write.
- All outputs registered/derived from state; no combinational path from inputs to outputs.
- start accepted at edge 0 → busy_o=1 from cycle 1.
- Final beat accepted at edge t → write_enable_o=1 in cycle t+1 (S includes final beat) → done_o=1 in cycle t+2 → IDLE, busy_o=0 in cycle t+3; next start accepted at edge t+3.
- beats_i==0: start at edge 0 → write_enable_o cycle 1, done_o cycle 2.
- Minimum operation length, start to idle: beats_i + 3 cycles with pe_valid_i held high.

## Configuration
- FLAGS_IRQ_EN defined: ports irq_o, irq_clr_i exist. irq_o set in the cycle after COMMIT if |S==1; stays high until irq_clr_i=1 or an accepted start_i (clear wins over the same-cycle set is not possible; set and clear never coincide with set taking priority over start). Reset clears.
- FLAGS_IRQ_EN undefined: ports and logic absent; behaviour otherwise identical.

## Test plan
- MAX_DIM=2, accum_i=0, beats_i=3, pe_flags 0001,0000,0100 on consecutive cycles → one write_enable_o with data_o=0x…0005, done_o one cycle later, busy_o low 3 cycles after last beat.
- accum_i=1, flags_prev_i=1000, beats_i=2, beats 0001,0001 with a pe_valid_i gap → data_o=0x9 at write; gap does not count.
- beats_i=0, accum_i=1, flags_prev_i=0110 → write_enable_o at cycle 1 with data_o=0x6, done_o at cycle 2.
- Restart: beats_i=4, after 2 beats (flags 1111) start_i again with accum_i=0, beats_i=1, beat 0010 → exactly one write, data_o=0x2; start_i during DONE ignored.
- rst_ni=0 for one cycle mid-COLLECT → all outputs 0 next cycle, no write_enable_o, subsequent op behaves normally.
- FLAGS_IRQ_EN: op committing 0x4 → irq_o rises cycle after write, holds until irq_clr_i; op committing 0x0 → irq_o stays 0.
